// File: rtl/lw_gpio_ctrl.sv
// lw_gpio_ctrl: Avalon-MM LED/switch controller with per-LED hardware blink, switch sync,
// edge capture and maskable irq. Define LW_GPIO_DEBOUNCE_EN to add per-bit switch debounce.
module lw_gpio_ctrl #(
  parameter int LED_W           = 8,
  parameter int SW_W            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV_RST   = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             readdatavalid,
  output logic             irq,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw
);

  if (LED_W < 1 || LED_W > 32 || SW_W < 1 || SW_W > 32 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("lw_gpio_ctrl: parameter out of range");
  end

  logic [LED_W-1:0] led_out, led_mode;
  logic [31:0]      blink_div, blink_cnt, rd_mux;
  logic             phase;
  logic [SW_W-1:0]  sync1, sw_db, sw_db_next, edge_cap, irq_mask, edge_clr;
  logic             wr_led_out, wr_led_mode, wr_div, wr_edge, wr_mask;

  assign wr_led_out  = write && (address == 3'd0);
  assign wr_led_mode = write && (address == 3'd1);
  assign wr_div      = write && (address == 3'd2);
  assign wr_edge     = write && (address == 3'd4);
  assign wr_mask     = write && (address == 3'd5);
  assign edge_clr    = wr_edge ? writedata[SW_W-1:0] : '0;

`ifdef LW_GPIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SW_W-1:0]  sync2;
  logic [CNT_W-1:0] db_cnt [SW_W];

  // A bit is accepted only after the synced value has disagreed with sw_db for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    sw_db_next = sw_db;
    for (int i = 0; i < SW_W; i++) begin
      if ((sync2[i] != sw_db[i]) && (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)))
        sw_db_next[i] = sync2[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync2 <= '0;
      for (int i = 0; i < SW_W; i++) db_cnt[i] <= '0;
    end else begin
      sync2 <= sync1;
      for (int i = 0; i < SW_W; i++) begin
        if ((sync2[i] == sw_db[i]) || (sw_db_next[i] != sw_db[i])) db_cnt[i] <= '0;
        else db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign sw_db_next = sync1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out  <= '0;
      led_mode <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      sync1    <= '0;
      sw_db    <= '0;
      irq      <= 1'b0;
      led      <= '0;
    end else begin
      if (wr_led_out)  led_out  <= writedata[LED_W-1:0];
      if (wr_led_mode) led_mode <= writedata[LED_W-1:0];
      if (wr_mask)     irq_mask <= writedata[SW_W-1:0];
      sync1    <= sw;
      sw_db    <= sw_db_next;
      // Set after clear so a new edge wins over a simultaneous write-1-clear.
      edge_cap <= (edge_cap & ~edge_clr) | (sw_db_next ^ sw_db);
      irq      <= |(edge_cap & irq_mask);
      led      <= led_out & (~led_mode | {LED_W{phase}});
    end
  end

  // Blink down-counter: phase toggles on each reload; a zero divider pins phase high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_div <= 32'(BLINK_DIV_RST);
      blink_cnt <= 32'(BLINK_DIV_RST);
      phase     <= 1'b0;
    end else if (wr_div) begin
      blink_div <= writedata;
      blink_cnt <= writedata;
    end else if (blink_cnt == '0) begin
      blink_cnt <= blink_div;
      phase     <= (blink_div == '0) ? 1'b1 : ~phase;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = 32'(led_out);
      3'd1:    rd_mux = 32'(led_mode);
      3'd2:    rd_mux = blink_div;
      3'd3:    rd_mux = 32'(sw_db);
      3'd4:    rd_mux = 32'(edge_cap);
      3'd5:    rd_mux = 32'(irq_mask);
      default: rd_mux = '0;
    endcase
  end

  // Handshake: read is sampled on a clock edge; readdatavalid pulses for exactly one
  // cycle on the following edge with readdata. No wait states, so no waitrequest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_lw_gpio_ctrl.sv
// tb_lw_gpio_ctrl: randomized bench for lw_gpio_ctrl with a register-level reference model
// and a read scoreboard. Follows the DUT build: LW_GPIO_DEBOUNCE_EN selects switch latency.
`timescale 1ns/1ps
module tb_lw_gpio_ctrl;
  localparam int LED_W = 8;
  localparam int SW_W  = 4;
  localparam int DB    = 4;
  localparam int BDR   = 3;
`ifdef LW_GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       address = '0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic             readdatavalid;
  logic             irq;
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  sw = '0;

  lw_gpio_ctrl #(
    .LED_W(LED_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DB), .BLINK_DIV_RST(BDR)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .irq(irq), .led(led), .sw(sw)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [LED_W-1:0] m_out, m_mode;
  logic [31:0]      m_div;
  logic [SW_W-1:0]  m_db, m_edge, m_mask;

  function automatic logic [31:0] model_rd(input int a);
    case (a)
      0: return 32'(m_out);
      1: return 32'(m_mode);
      2: return m_div;
      3: return 32'(m_db);
      4: return 32'(m_edge);
      5: return 32'(m_mask);
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    case (a)
      0: m_out = d[LED_W-1:0];
      1: m_mode = d[LED_W-1:0];
      2: m_div = d;
      4: m_edge = m_edge & ~d[SW_W-1:0];
      5: m_mask = d[SW_W-1:0];
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_out = '0; m_mode = '0; m_div = 32'(BDR);
    m_db = '0; m_edge = '0; m_mask = '0;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic rd_issued;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) rd_issued <= 1'b0;
    else rd_issued <= read;
  end

  always @(negedge clk) begin
    if (!reset && (rd_issued || readdatavalid)) begin
      check("rdv_timing", 32'(readdatavalid), 32'(rd_issued));
      if (readdatavalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: readdata 0x%0h with no read outstanding", readdata);
        end else begin
          check("readdata", readdata, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input int a);
    address = 3'(a);
    read = 1'b1;
    exp_q.push_back(model_rd(a));
    step();
    read = 1'b0;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    address = 3'(a);
    writedata = d;
    write = 1'b1;
    step();
    write = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_rw(input int a, input logic [31:0] d);
    address = 3'(a);
    writedata = d;
    read = 1'b1;
    write = 1'b1;
    exp_q.push_back(model_rd(a));
    step();
    read = 1'b0;
    write = 1'b0;
    model_write(a, d);
  endtask

  // Flip one switch and read SW_IN on the last cycle before and the first cycle after
  // the expected debounced update.
  task automatic toggle_check(input int b);
    logic [SW_W-1:0] bit_m;
    bit_m = SW_W'(1) << b;
    sw = sw ^ bit_m;
    repeat (LAT - 1) step();
    bus_read(3);
    m_db = m_db ^ bit_m;
    m_edge = m_edge | bit_m;
    bus_read(3);
    bus_read(4);
  endtask

  task automatic check_irq(input string name);
    @(negedge clk);
    check(name, 32'(irq), 32'(|(m_edge & m_mask)));
    step();
  endtask

  // Blink LEDs must alternate between 0 and their LED_OUT value with half period
  // m_div+1 cycles; non-blink LEDs follow LED_OUT.
  task automatic check_blink(input int cycles);
    logic [LED_W-1:0] bm, cur, prev;
    int last;
    int changes;
    last = -1;
    changes = 0;
    bm = m_out & m_mode;
    repeat (3) step();
    @(negedge clk);
    prev = led & m_mode;
    for (int i = 1; i < cycles; i++) begin
      @(negedge clk);
      cur = led & m_mode;
      check("led_steady", 32'(led & ~m_mode), 32'(m_out & ~m_mode));
      if (m_div == 0) begin
        check("led_frozen", 32'(cur), 32'(bm));
      end else begin
        check("led_blink_level", 32'((cur == bm) || (cur == '0)), 32'd1);
        if (cur != prev) begin
          if (last >= 0) check("blink_half_period", 32'(i - last), m_div + 1);
          last = i;
          changes++;
        end
      end
      prev = cur;
    end
    if (m_div != 0) check("blink_toggled", 32'(changes >= 2), 32'd1);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 8; a++) bus_read(a);

    // blink with reset divider, then frozen, then random dividers
    bus_write(0, 32'hA5);
    bus_write(1, 32'h0F);
    check_blink(20);
    bus_write(2, 32'd0);
    check_blink(10);
    bus_read(2);
    for (int k = 0; k < 2; k++) begin
      d = $urandom_range(4, 1);
      bus_write(0, $urandom | 32'h1);
      bus_write(1, $urandom | 32'h1);
      bus_write(2, 32'(d));
      check_blink(4 * (d + 1) + 3);
    end

    // simultaneous read/write returns old value; ignored addresses
    bus_rw(0, $urandom);
    bus_read(0);
    bus_write(3, $urandom);
    bus_write(6, $urandom);
    bus_write(7, $urandom);
    for (int k = 0; k < 8; k++) bus_read($urandom_range(7, 0));

`ifdef LW_GPIO_DEBOUNCE_EN
    sw[0] = 1'b1;
    repeat (DB - 1) step();
    sw[0] = 1'b0;
    repeat (12) step();
    bus_read(3);
    bus_read(4);
`endif

    toggle_check(0);

    // irq follows mask and clear one cycle late
    bus_write(5, 32'h1);
    @(negedge clk) check("irq_before_mask", 32'(irq), 32'd0);
    @(negedge clk) check("irq_after_mask", 32'(irq), 32'd1);
    step();
    bus_write(4, 32'h1);
    @(negedge clk) check("irq_before_clear", 32'(irq), 32'd1);
    @(negedge clk) check("irq_after_clear", 32'(irq), 32'd0);
    step();

    // clear in the same cycle as a capture: the capture wins
    sw[0] = 1'b0;
    repeat (LAT - 1) step();
    bus_write(4, 32'h1);
    m_db[0] = 1'b0;
    m_edge[0] = 1'b1;
    bus_read(4);
    bus_read(3);
    check_irq("irq_set_wins");

    toggle_check(2);

    for (int k = 0; k < 6; k++) begin
      toggle_check($urandom_range(SW_W - 1, 0));
      if ($urandom_range(1, 0) == 1) bus_write(5, $urandom);
      if ($urandom_range(1, 0) == 1) bus_write(4, $urandom);
      step();
      check_irq("irq_random");
    end

    // asynchronous reset mid-blink with all edges captured
    sw = '0;
    repeat (LAT + 2) step();
    m_edge = m_edge | m_db;
    m_db = '0;
    sw = '1;
    repeat (LAT + 2) step();
    m_edge = '1;
    m_db = '1;
    bus_write(5, 32'hF);
    bus_write(0, 32'hA5);
    bus_write(1, 32'h0F);
    bus_write(2, 32'd3);
    bus_read(4);
    repeat (3) step();
    check_irq("irq_pre_reset");
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_rdv", 32'(readdatavalid), 32'd0);
    check("async_rst_readdata", readdata, 32'd0);
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    bus_read(0);
    bus_read(1);
    bus_read(2);
    bus_read(5);
    bus_read(6);
    bus_read(7);
    repeat (LAT + 2) step();
    m_db = '1;
    m_edge = '1;
    bus_read(3);
    bus_read(4);
    @(negedge clk) check("post_rst_led", 32'(led), 32'd0);
    check_irq("post_rst_irq");

    repeat (4) step();
    check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lw_gpio_ctrl.md
Name: lw_gpio_ctrl

Overview:
Parametrised Avalon-MM slave on the HPS lightweight H2F bus that replaces plain LED/switch PIO exports. Per-LED hardware blink with a programmable prescaler. Synchronises (and optionally debounces) switch inputs, captures switch edges, and raises a maskable interrupt. Instantiated in soc_system fabric, driving board LED[] and sampling SW[].

Parameters:
LED_W, 8, number of LED outputs (1..32)
SW_W, 4, number of switch inputs (1..32)
DEBOUNCE_CYCLES, 500000, stable-input cycles before debounced switch updates (10 ms at 50 MHz), >=1
BLINK_DIV_RST, 25000000, reset value of blink prescaler reload

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
address  in  3  word address
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
readdata  out  32  read data, valid with readdatavalid
readdatavalid  out  1  one-cycle pulse, 1 cycle after read
irq  out  1  level interrupt, registered
led  out  LED_W  LED drive
sw  in  SW_W  asynchronous switch inputs

Behaviour:
- Register map (word addr), unused upper bits read 0:
  0 LED_OUT RW [LED_W-1:0]
  1 LED_MODE RW [LED_W-1:0]; 1 = blink
  2 BLINK_DIV RW [31:0]
  3 SW_IN RO [SW_W-1:0], debounced value
  4 EDGE_CAP RW1C [SW_W-1:0]
  5 IRQ_MASK RW [SW_W-1:0]
  6,7 read 0; writes ignored. Writes to SW_IN ignored.
- Reset values: LED_OUT=0, LED_MODE=0, BLINK_DIV=BLINK_DIV_RST, blink counter=BLINK_DIV_RST, phase=0, sync/debounced regs=0, debounce counters=0, EDGE_CAP=0, IRQ_MASK=0, irq=0, led=0, readdata=0, readdatavalid=0.
- Read: readdata/readdatavalid registered, 1-cycle latency. read and write in the same cycle: both performed; read returns pre-write value.
- Blink: down-counter. At 0 it reloads BLINK_DIV and toggles phase, so phase period = 2*(BLINK_DIV+1) cycles. A write to BLINK_DIV reloads the counter in the next cycle; phase is unchanged. BLINK_DIV=0 freezes phase at 1 (blink LEDs steady).
- led[i] registered = LED_OUT[i] & (~LED_MODE[i] | phase). Updates 1 cycle after the register or phase change.
- Switch path: 2-FF synchroniser per bit, then debounce (see optional feature) producing sw_db.
- Edge capture: EDGE_CAP[i] sets on any change of sw_db[i] (rise or fall). Write-1 clears. A set and a clear on the same bit in the same cycle: set wins.
- irq <= |(EDGE_CAP & IRQ_MASK), registered. Deasserts 1 cycle after clear or mask.
- Reset mid-operation: all state returns asynchronously to reset values. A switch held high through reset produces a rising sw_db edge (and capture) after the synchroniser/debounce delay.

Optional Feature:
LW_GPIO_DEBOUNCE_EN.
- Defined: per-bit counter. While synced input != sw_db, count. When the count reaches DEBOUNCE_CYCLES-1, update sw_db and clear the counter. Clear the counter whenever input == sw_db.
  - Latency from sw change to sw_db: 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Undefined: sw_db = synchroniser output, latency 2 cycles, no counters generated.

Test Plan:
(Bench params: DEBOUNCE_CYCLES=4, BLINK_DIV_RST=3, LED_W=8, SW_W=4.)
- Reset then read addr 0..7 -> 0,0,3,0,0,0,0,0. readdatavalid high exactly 1 cycle after each read. led=0, irq=0.
- Write LED_OUT=0xA5, LED_MODE=0x0F -> led upper nibble steady 0xA. Low nibble alternates 0x0/0x5 every 4 cycles (period 8). Write BLINK_DIV=0 -> led=0xA5 steady.
- Debounce on: pulse sw[0] high for 3 cycles -> SW_IN stays 0, EDGE_CAP=0. Hold sw[0] high -> SW_IN=0x1 after 6 cycles, EDGE_CAP=0x1.
- Set IRQ_MASK=0x1 with EDGE_CAP[0]=1 -> irq=1 next cycle. Write EDGE_CAP=0x1 -> irq=0 one cycle later. Write 0x1 in the same cycle sw_db[0] falls -> EDGE_CAP[0] stays 1.
- Debounce off: toggle sw[2] -> SW_IN[2] follows after 2 cycles, EDGE_CAP[2]=1.
- Assert reset mid-blink with EDGE_CAP=0xF -> all outputs and registers return to reset values immediately, without waiting for a clock edge.
